// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM driving the fetch unit (start, run, stall,
// branch redirect, halt). All outputs are registered; one branch request
// arriving during a stall is held in a single-entry pending slot.
module fetch_sequencer #(
   parameter int ADDR_W = 9,
   parameter int IMM_W  = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_address,
   input  logic              stall,
   input  logic              br_req,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              bri_req,
   input  logic [IMM_W-1:0]  bri_imm,
   input  logic              halt,
   output logic              fetch_unit_en,
   output logic              init,
   output logic              branch,
   output logic              branchi,
   output logic [ADDR_W-1:0] startAddress,
   output logic [ADDR_W-1:0] target,
   output logic [IMM_W-1:0]  immediate,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_HALTED
   } state_t;

   state_t            state, state_nx;

   logic              fen_nx, init_nx, br_nx, bri_nx, busy_nx, done_nx;
   logic [ADDR_W-1:0] sa_nx, tgt_nx;
   logic [IMM_W-1:0]  imm_nx;
   logic [CNT_W-1:0]  cnt_nx;

   logic              pend_vld, pend_vld_nx;
   logic              pend_br, pend_br_nx;
   logic [ADDR_W-1:0] pend_tgt, pend_tgt_nx;
   logic [IMM_W-1:0]  pend_imm, pend_imm_nx;

   // State, output and pending registers; everything clears on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         fetch_unit_en <= 1'b0;
         init          <= 1'b0;
         branch        <= 1'b0;
         branchi       <= 1'b0;
         startAddress  <= '0;
         target        <= '0;
         immediate     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         fetch_count   <= '0;
         pend_vld      <= 1'b0;
         pend_br       <= 1'b0;
         pend_tgt      <= '0;
         pend_imm      <= '0;
      end else begin
         state         <= state_nx;
         fetch_unit_en <= fen_nx;
         init          <= init_nx;
         branch        <= br_nx;
         branchi       <= bri_nx;
         startAddress  <= sa_nx;
         target        <= tgt_nx;
         immediate     <= imm_nx;
         busy          <= busy_nx;
         done          <= done_nx;
         fetch_count   <= cnt_nx;
         pend_vld      <= pend_vld_nx;
         pend_br       <= pend_br_nx;
         pend_tgt      <= pend_tgt_nx;
         pend_imm      <= pend_imm_nx;
      end
   end

   // Next-state and next-output decode; control pulses default low, data holds.
   always_comb begin
      state_nx    = state;
      fen_nx      = 1'b0;
      init_nx     = 1'b0;
      br_nx       = 1'b0;
      bri_nx      = 1'b0;
      sa_nx       = startAddress;
      tgt_nx      = target;
      imm_nx      = immediate;
      pend_vld_nx = pend_vld;
      pend_br_nx  = pend_br;
      pend_tgt_nx = pend_tgt;
      pend_imm_nx = pend_imm;
      cnt_nx      = fetch_count;

      // Count advance cycles seen in RUN; saturate at all-ones.
      if (state == S_RUN && fetch_unit_en && fetch_count != '1)
         cnt_nx = fetch_count + CNT_W'(1);

      case (state)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_nx    = S_LOAD;
               init_nx     = 1'b1;
               fen_nx      = 1'b1;
               sa_nx       = start_address;
               cnt_nx      = '0;
               pend_vld_nx = 1'b0;
            end
         end
         S_LOAD: begin
            state_nx = S_RUN;
            fen_nx   = !stall;
         end
         S_RUN: begin
            if (halt) begin
               state_nx    = S_HALTED;
               pend_vld_nx = 1'b0;
            end else if (stall) begin
               // Newest request replaces whatever is pending.
               if (br_req) begin
                  pend_vld_nx = 1'b1;
                  pend_br_nx  = 1'b1;
                  pend_tgt_nx = br_target;
               end else if (bri_req) begin
                  pend_vld_nx = 1'b1;
                  pend_br_nx  = 1'b0;
                  pend_imm_nx = bri_imm;
               end
            end else begin
               fen_nx = 1'b1;
               if (br_req) begin
                  br_nx       = 1'b1;
                  tgt_nx      = br_target;
                  pend_vld_nx = 1'b0;
               end else if (bri_req) begin
                  bri_nx      = 1'b1;
                  imm_nx      = bri_imm;
                  pend_vld_nx = 1'b0;
               end else if (pend_vld) begin
                  pend_vld_nx = 1'b0;
                  if (pend_br) begin
                     br_nx  = 1'b1;
                     tgt_nx = pend_tgt;
                  end else begin
                     bri_nx = 1'b1;
                     imm_nx = pend_imm;
                  end
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      busy_nx = (state_nx == S_LOAD) || (state_nx == S_RUN);
      done_nx = (state_nx == S_HALTED);
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that drives the fetch unit's control inputs: fetch enable, init, absolute branch, relative branch, start address, branch target and immediate.
- Sequences program start, free-running fetch, pipeline stalls, branch redirection and halt.
- Holds one branch request that arrives during a stall, so no redirect is lost.
- Sits between the decode/execute control logic and the fetch unit. Also keeps a count of fetch-advance cycles.

Parameters:
- ADDR_W, 9, width of PC, start address and branch target.
- IMM_W, 6, width of relative-branch immediate, passed through unmodified.
- CNT_W, 16, width of the fetch-advance counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a program at start_address; honoured in IDLE or HALTED.
- start_address  in  ADDR_W  program entry PC.
- stall  in  1  freeze fetch this cycle.
- br_req  in  1  absolute branch request.
- br_target  in  ADDR_W  absolute target.
- bri_req  in  1  relative branch request.
- bri_imm  in  IMM_W  relative immediate.
- halt  in  1  stop fetching; honoured in RUN only.
- fetch_unit_en  out  1  fetch unit enable.
- init  out  1  load startAddress.
- branch  out  1  load target.
- branchi  out  1  add immediate.
- startAddress  out  ADDR_W  start address to fetch unit.
- target  out  ADDR_W  branch target to fetch unit.
- immediate  out  IMM_W  immediate to fetch unit.
- busy  out  1  high in LOAD or RUN.
- done  out  1  high in HALTED.
- fetch_count  out  CNT_W  count of RUN cycles with fetch_unit_en=1.

Behaviour:
- Reset: asynchronous on rst_n=0. State=IDLE. Every output register and the pending register clear to 0.
- All outputs are registered. A request sampled at edge k appears on the outputs after edge k. The fetch unit acts on it at edge k+1.
- States are IDLE, LOAD, RUN and HALTED.
- IDLE:
  - All control outputs are 0.
  - start=1 → LOAD. On the same edge: init=1, fetch_unit_en=1, startAddress<=start_address, fetch_count<=0, pending cleared.
- LOAD:
  - Lasts exactly one cycle, then → RUN.
  - init drops to 0.
  - start, halt, br_req and bri_req sampled in LOAD are ignored.
  - fetch_unit_en is set to !stall.
- RUN, evaluated in priority order at each edge:
  1. halt=1 → HALTED. fetch_unit_en, branch and branchi become 0. Pending is dropped.
  2. stall=1: fetch_unit_en=0, branch=0, branchi=0. A new request is captured into pending:
     - br_req wins over bri_req.
     - A newer request overwrites an existing pending one.
  3. stall=0 with a new request: fetch_unit_en=1 and branch=1 (target<=br_target) or branchi=1 (immediate<=bri_imm). br_req wins over bri_req. The new request also discards any pending request.
  4. stall=0 with pending valid: fetch_unit_en=1, pending is issued as branch/branchi, pending cleared.
  5. Otherwise: fetch_unit_en=1, branch=0, branchi=0 (sequential fetch).
- branch and branchi are never high together. Each is high for exactly one cycle per issued request.
- target, immediate and startAddress hold their last value when not being updated.
- fetch_count:
  - Increments on each edge where state is RUN and the registered fetch_unit_en is 1.
  - Saturates at 2^CNT_W−1.
  - Cleared only on entry to LOAD or by reset.
- HALTED:
  - done=1, all control outputs 0, fetch_count holds.
  - start=1 → LOAD, with the same actions as from IDLE.
- Reset asserted mid-RUN: immediate return to IDLE, outputs 0, pending lost.
- A request that arrives on the same edge as halt is discarded.

Test Plan:
1. Reset then start with start_address=0x040 → next cycle init=1, fetch_unit_en=1, startAddress=0x040, busy=1. The cycle after: init=0. After 5 RUN cycles, fetch_count=5.
2. In RUN, stall=0 and br_req with br_target=0x1A3 → branch=1 and target=0x1A3 for exactly one cycle, then sequential fetch resumes.
3. stall=1 for 3 cycles; bri_req with bri_imm=0x05 in the 2nd stall cycle → fetch_unit_en=0 for those cycles, branchi=1 with immediate=0x05 in the first cycle after stall drops, and fetch_count unchanged during the stall.
4. br_req=1 and bri_req=1 together (target=0x010, imm=0x3F) → branch=1, target=0x010, branchi=0. A pending bri request discarded by a concurrent br_req with stall=0 is never issued.
5. halt with br_req in the same cycle → HALTED: done=1, fetch_unit_en=0, no branch pulse. Then start with start_address=0x000 → LOAD with fetch_count cleared.
6. rst_n pulsed low asynchronously mid-RUN with a pending request → outputs 0 immediately, state IDLE, and no branch issued after release.
